// File: rtl/hub75_rx.sv
// HUB75 panel sniffer: captures shifted columns per latch and replays them as (row, col, plane, rgb) pixels.
// Latency: first pixel 1 clk after the synchronized latch rise; 1 pixel/clk sustained.
// Backpressure: out_* hold while out_valid && !out_ready; a latch arriving mid-unload is dropped and flagged.
module hub75_rx #(
    parameter int NCOL = 64,
    parameter int ONW  = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           hub_r0,
    input  logic           hub_g0,
    input  logic           hub_b0,
    input  logic           hub_r1,
    input  logic           hub_g1,
    input  logic           hub_b1,
    input  logic [3:0]     hub_a,
    input  logic           hub_sclk,
    input  logic           hub_latch,
    input  logic           hub_blank,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [3:0]     out_row,
    output logic [5:0]     out_col,
    output logic [1:0]     out_plane,
    output logic [5:0]     out_rgb,
    output logic [ONW-1:0] on_time,
    output logic           on_valid,
    input  logic           clr_err,
    output logic           err_overflow,
    output logic           err_overrun
);

    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CW:0]    NCOL_C  = (CW+1)'(NCOL);
    localparam logic [CW:0]    WONE    = (CW+1)'(1);
    localparam logic [CW-1:0]  CONE    = CW'(1);
    localparam logic [ONW-1:0] CNT_MAX = '1;
    localparam logic [ONW-1:0] CNT_ONE = ONW'(1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    logic [2:0] sclk_sr, latch_sr, blank_sr;
    logic [5:0] dat_s1, dat_s2, dat_s3;
    logic [3:0] a_s1, a_s2, a_s3;

    // Data and address get a third stage so they line up with the edge-compare stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr  <= '0;
            latch_sr <= '0;
            blank_sr <= '1;
            dat_s1   <= '0;
            dat_s2   <= '0;
            dat_s3   <= '0;
            a_s1     <= '0;
            a_s2     <= '0;
            a_s3     <= '0;
        end else begin
            sclk_sr  <= {sclk_sr[1:0], hub_sclk};
            latch_sr <= {latch_sr[1:0], hub_latch};
            blank_sr <= {blank_sr[1:0], hub_blank};
            dat_s1   <= {hub_r1, hub_g1, hub_b1, hub_r0, hub_g0, hub_b0};
            dat_s2   <= dat_s1;
            dat_s3   <= dat_s2;
            a_s1     <= hub_a;
            a_s2     <= a_s1;
            a_s3     <= a_s2;
        end
    end

    logic sclk_rise, latch_rise, blank_rise, blank_fall;
    assign sclk_rise  =  sclk_sr[1]  & ~sclk_sr[2];
    assign latch_rise =  latch_sr[1] & ~latch_sr[2];
    assign blank_rise =  blank_sr[1] & ~blank_sr[2];
    assign blank_fall = ~blank_sr[1] &  blank_sr[2];

    state_t         state_q, state_d;
    logic           wsel_q;
    logic [CW:0]    wcol_q, ncols_q;
    logic [CW-1:0]  col_q;
    logic           hist_vld;
    logic           swap, busy_latch, wsel_eff, wr_en, last_beat;
    logic [CW:0]    wcol_eff;

    // A latch resolves before a coincident sclk, so the new column lands at index 0 of the fresh bank.
    always_comb begin
        swap       = latch_rise && (state_q == IDLE);
        busy_latch = latch_rise && (state_q != IDLE);
        wsel_eff   = swap ? ~wsel_q : wsel_q;
        wcol_eff   = latch_rise ? '0 : wcol_q;
        wr_en      = sclk_rise && (wcol_eff != NCOL_C);
        last_beat  = ({1'b0, col_q} + WONE) == ncols_q;
    end

    logic [5:0] bank0 [NCOL];
    logic [5:0] bank1 [NCOL];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wsel_eff)
                bank1[wcol_eff[CW-1:0]] <= dat_s3;
            else
                bank0[wcol_eff[CW-1:0]] <= dat_s3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsel_q       <= 1'b0;
            wcol_q       <= '0;
            ncols_q      <= '0;
            out_row      <= '0;
            out_plane    <= '0;
            hist_vld     <= 1'b0;
            err_overflow <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            if (swap) begin
                wsel_q    <= ~wsel_q;
                ncols_q   <= wcol_q;
                out_row   <= a_s3;
                out_plane <= (hist_vld && (a_s3 == out_row)) ? out_plane + 2'd1 : 2'd0;
                hist_vld  <= 1'b1;
            end
            wcol_q <= wr_en ? wcol_eff + WONE : wcol_eff;
            if (sclk_rise && !wr_en)
                err_overflow <= 1'b1;
            else if (clr_err)
                err_overflow <= 1'b0;
            if (busy_latch)
                err_overrun <= 1'b1;
            else if (clr_err)
                err_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            if (swap)
                col_q <= '0;
            else if ((state_q == SEND) && out_ready)
                col_q <= last_beat ? '0 : col_q + CONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (swap && (wcol_q != '0)) state_d = SEND;
            SEND:    if (out_ready && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [5:0] rd_rgb;
    assign rd_rgb    = wsel_q ? bank0[col_q] : bank1[col_q];
    assign out_valid = (state_q == SEND);
    assign out_rgb   = out_valid ? rd_rgb : 6'd0;
    assign out_col   = 6'(col_q);

    logic [ONW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            on_time  <= '0;
            on_valid <= 1'b0;
        end else begin
            on_valid <= blank_rise;
            if (blank_rise)
                on_time <= cnt_q;
            if (blank_fall)
                cnt_q <= '0;
            else if (!blank_sr[1] && (cnt_q != CNT_MAX))
                cnt_q <= cnt_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: a queue-based pixel model checked every output cycle, plus literal spot checks.
module tb_hub75_rx;
    localparam int NCOL = 64;
    localparam int ONW  = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
    logic [3:0] hub_a;
    logic hub_sclk, hub_latch, hub_blank;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [3:0] out_row;
    logic [5:0] out_col;
    logic [1:0] out_plane;
    logic [5:0] out_rgb;
    logic [ONW-1:0] on_time;
    logic on_valid;
    logic clr_err;
    logic err_overflow, err_overrun;

    hub75_rx #(.NCOL(NCOL), .ONW(ONW)) dut (
        .clk(clk), .rst_n(rst_n),
        .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
        .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
        .hub_a(hub_a), .hub_sclk(hub_sclk), .hub_latch(hub_latch), .hub_blank(hub_blank),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_plane(out_plane), .out_rgb(out_rgb),
        .on_time(on_time), .on_valid(on_valid),
        .clr_err(clr_err), .err_overflow(err_overflow), .err_overrun(err_overrun)
    );

    typedef struct packed {
        logic [3:0] row;
        logic [5:0] col;
        logic [1:0] plane;
        logic [5:0] rgb;
    } pix_t;

    pix_t       exp_q[$];
    logic [5:0] cur_cols[$];
    int         first_planes[$];
    bit         hist_vld = 0;
    logic [3:0] hist_row = '0;
    logic [1:0] hist_plane = '0;
    int checks = 0;
    int errors = 0;
    int beats = 0;
    int rdy_mode = 1;
    bit stall_prev = 0;
    logic [3:0] sv_row;
    logic [5:0] sv_col, sv_rgb;
    logic [1:0] sv_plane;
    pix_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else               out_ready = (rdy_mode == 1);
    end

    // Pixel checker: every presented pixel must be the head of the model queue; stalls must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_row", out_row, sv_row);
                chk("hold_col", out_col, sv_col);
                chk("hold_plane", out_plane, sv_plane);
                chk("hold_rgb", out_rgb, sv_rgb);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", out_valid, 0);
                end else begin
                    e = exp_q[0];
                    chk("pix_row", out_row, e.row);
                    chk("pix_col", out_col, e.col);
                    chk("pix_plane", out_plane, e.plane);
                    chk("pix_rgb", out_rgb, e.rgb);
                    if (out_ready) begin
                        if (out_col == 6'd0) first_planes.push_back(int'(out_plane));
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            sv_row = out_row; sv_col = out_col; sv_plane = out_plane; sv_rgb = out_rgb;
        end
    end

    // Model of a latch: busy unloader drops the row, otherwise the row's first NCOL columns are queued.
    task automatic model_latch(input logic [3:0] row);
        logic [1:0] pl;
        int n;
        if (exp_q.size() == 0) begin
            pl = (hist_vld && row == hist_row) ? hist_plane + 2'd1 : 2'd0;
            hist_vld = 1; hist_row = row; hist_plane = pl;
            n = (cur_cols.size() > NCOL) ? NCOL : cur_cols.size();
            for (int i = 0; i < n; i++)
                exp_q.push_back('{row: row, col: 6'(i), plane: pl, rgb: cur_cols[i]});
        end
        cur_cols.delete();
    endtask

    task automatic shift_col(input logic [5:0] rgb);
        {hub_r1, hub_g1, hub_b1, hub_r0, hub_g0, hub_b0} = rgb;
        tick(3);
        hub_sclk = 1'b1;
        tick(3);
        hub_sclk = 1'b0;
        cur_cols.push_back(rgb);
    endtask

    task automatic do_latch(input logic [3:0] row);
        hub_a = row;
        model_latch(row);
        tick(3);
        hub_latch = 1'b1;
        tick(3);
        hub_latch = 1'b0;
        tick(3);
    endtask

    task automatic latch_with_sclk(input logic [3:0] row, input logic [5:0] rgb);
        hub_a = row;
        {hub_r1, hub_g1, hub_b1, hub_r0, hub_g0, hub_b0} = rgb;
        model_latch(row);
        cur_cols.push_back(rgb);
        tick(3);
        hub_latch = 1'b1; hub_sclk = 1'b1;
        tick(3);
        hub_latch = 1'b0; hub_sclk = 1'b0;
        tick(3);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            tick(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
        tick(2);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(2);
    endtask

    task automatic blank_test(input int n, input int lo, input int hi, input string name);
        int w = 0;
        hub_blank = 1'b0;
        tick(n);
        hub_blank = 1'b1;
        while (!on_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_strobe"}, on_valid, 1);
        if (on_valid) chk_rng({name, "_on_time"}, int'(on_time), lo, hi);
        @(negedge clk);
        chk({name, "_one_cycle"}, on_valid, 0);
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int exp_planes[13] = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 1, 0, 2, 0};
        {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1} = '0;
        hub_a = '0; hub_sclk = 1'b0; hub_latch = 1'b0; hub_blank = 1'b1;
        clr_err = 1'b0;
        rst_n = 1'b0;
        tick(4);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_plane", out_plane, 0);
        chk("rst_out_rgb", out_rgb, 0);
        chk("rst_on_time", on_time, 0);
        chk("rst_on_valid", on_valid, 0);
        chk("rst_err_overflow", err_overflow, 0);
        chk("rst_err_overrun", err_overrun, 0);
        tick(1);
        rst_n = 1'b1;
        tick(8);
        chk("no_spurious_on_valid", on_valid, 0);

        // Row 5 latched four times, then row 6.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 2; c++) shift_col(6'((r * 2 + c + 1) * 5));
            do_latch((r < 4) ? 4'd5 : 4'd6);
            drain("drain_planes");
        end

        // Full 64-column row, rgb = column index.
        beats = 0;
        for (int k = 0; k < 64; k++) shift_col(6'(k));
        do_latch(4'd5);
        drain("drain_full_row");
        chk("full_row_beats", beats, 64);
        chk("full_row_out_row", out_row, 5);
        chk("full_row_valid_low", out_valid, 0);
        chk("full_row_no_overflow", err_overflow, 0);

        // Overflow: 70 columns, only 64 captured.
        beats = 0;
        for (int k = 0; k < 70; k++) shift_col(6'(k * 3));
        do_latch(4'd7);
        drain("drain_overflow");
        chk("overflow_beats", beats, 64);
        chk("overflow_flag", err_overflow, 1);
        pulse_clr();
        chk("overflow_cleared", err_overflow, 0);

        // Overrun: second latch while the first row is stalled.
        rdy_mode = 0;
        beats = 0;
        for (int k = 0; k < 4; k++) shift_col(6'(40 + k));
        do_latch(4'd2);
        tick(5);
        chk("overrun_stalled_valid", out_valid, 1);
        shift_col(6'h11);
        shift_col(6'h22);
        do_latch(4'd3);
        tick(2);
        chk("overrun_flag", err_overrun, 1);
        chk("overrun_col_held", out_col, 0);
        rdy_mode = 1;
        drain("drain_overrun");
        chk("overrun_beats", beats, 4);
        pulse_clr();
        chk("overrun_cleared", err_overrun, 0);

        // sclk rise coincident with latch rise.
        beats = 0;
        shift_col(6'h01);
        shift_col(6'h02);
        latch_with_sclk(4'd4, 6'h2A);
        drain("drain_coincident_a");
        shift_col(6'h15);
        do_latch(4'd4);
        drain("drain_coincident_b");
        chk("coincident_beats", beats, 4);

        // Random backpressure.
        beats = 0;
        rdy_mode = 2;
        for (int k = 0; k < 20; k++) shift_col(6'($urandom_range(0, 63)));
        do_latch(4'd9);
        drain("drain_random");
        rdy_mode = 1;
        chk("random_beats", beats, 20);

        // Zero-column latch still advances the plane history.
        do_latch(4'd9);
        tick(5);
        chk("zero_col_idle", out_valid, 0);
        shift_col(6'h3F);
        shift_col(6'h00);
        do_latch(4'd9);
        drain("drain_after_zero");

        blank_test(200, 198, 202, "blank200");
        blank_test(5000, 4095, 4095, "blank5000");

        // Reset mid-unload aborts the row and forgets the plane history.
        rdy_mode = 0;
        for (int k = 0; k < 3; k++) shift_col(6'(k + 7));
        do_latch(4'd1);
        tick(3);
        chk("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        cur_cols.delete();
        hist_vld = 0;
        @(negedge clk);
        chk("mid_reset_valid", out_valid, 0);
        chk("mid_reset_col", out_col, 0);
        tick(2);
        rst_n = 1'b1;
        rdy_mode = 1;
        tick(4);
        shift_col(6'h05);
        shift_col(6'h06);
        do_latch(4'd1);
        drain("drain_post_reset");

        chk("first_planes_count", first_planes.size(), 13);
        for (int i = 0; i < 13; i++)
            if (i < first_planes.size()) chk("first_plane_seq", first_planes[i], exp_planes[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 SHALL have parameter NCOL, default 64, meaning the maximum columns captured per row (power of 2, 2..64).
REQ-002 SHALL have parameter ONW, default 12, meaning the width of the blank-low duration counter.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1  input  1 each  panel serial colour data.
REQ-006 hub_a  input  4  panel row address.
REQ-007 hub_sclk, hub_latch, hub_blank  input  1 each  panel shift clock, latch and blank (blank high = dark).
REQ-008 out_valid  output  1  a pixel is presented.
REQ-009 out_ready  input  1  the consumer accepts the pixel.
REQ-010 out_row  output  4  row of the presented pixel.
REQ-011 out_col  output  6  column index of the presented pixel (arrival order, 0 = first shifted).
REQ-012 out_plane  output  2  bit plane of the presented pixel.
REQ-013 out_rgb  output  6  pixel bits {r1,g1,b1,r0,g0,b0}.
REQ-014 on_time  output  ONW  clk count of the last blank-low interval; on_valid  output  1  single-cycle strobe when on_time updates.
REQ-015 clr_err  input  1  clears the sticky error flags; err_overflow, err_overrun  output  1 each  sticky error flags.

Function
REQ-016 All hub_* inputs SHALL pass through a 2-flop synchronizer; edges SHALL be detected by comparing stage 2 with a stage-3 copy; data and hub_a SHALL be delayed so they align with the sclk and latch stage-3 samples.
REQ-017 Inputs require hub_sclk high ≥2 clk and low ≥2 clk, and data stable ≥2 clk around the sclk rise; behaviour outside this is undefined.
REQ-018 On a detected sclk rise, the aligned 6 data bits SHALL be written to the shift bank at index wcol, and wcol SHALL increment.
REQ-019 On an sclk rise with wcol == NCOL, the data SHALL be discarded and err_overflow SHALL be set; wcol SHALL not wrap.
REQ-020 Two banks, each NCOL x 6 (shift, unload), SHALL be used; on a detected latch rise with the unloader IDLE, the banks SHALL swap, and row (aligned hub_a), ncols = wcol and the plane SHALL be captured; wcol SHALL be set to 0.
REQ-021 Plane rule: if the latched row equals the previously latched row, plane = (prev plane + 1) mod 4; otherwise plane = 0. The first latch after reset gives plane 0.
REQ-022 On a latch rise with the unloader not IDLE: no swap, row/plane not updated, err_overrun set, wcol set to 0.
REQ-023 The unloader FSM SHALL have states IDLE and SEND. IDLE→SEND on swap when ncols > 0; a swap with ncols == 0 SHALL remain IDLE and still update the plane history.
REQ-024 In SEND, out_valid = 1 starting the cycle after the swap; out_col starts at 0; out_* SHALL be held stable while out_valid && !out_ready.
REQ-025 Each out_valid && out_ready cycle SHALL advance out_col by 1; the handshake at out_col == ncols-1 SHALL return the FSM to IDLE with out_valid = 0 the next cycle. Full throughput is 1 pixel/clk.
REQ-026 A latch rise in the same cycle as the final handshake SHALL be treated as unloader-busy (REQ-022).
REQ-027 An sclk rise in the same cycle as a latch rise: the latch SHALL take effect first, and the data SHALL be written to the new shift bank at index 0, leaving wcol = 1.
REQ-028 The on-time counter SHALL clear on a detected blank fall, increment each clk while the synchronized blank is low, and saturate at 2^ONW-1; on a detected blank rise, on_time <= counter and on_valid pulses for 1 cycle.
REQ-029 clr_err SHALL clear both error flags; a set event in the same cycle SHALL take priority over the clear.

Reset
REQ-030 On rst_n low: out_valid=0, out_row=0, out_col=0, out_plane=0, out_rgb=0, on_time=0, on_valid=0, err_*=0, FSM=IDLE, wcol=0, plane history invalid, synchronizer stages = 0 except the blank stages = 1.
REQ-031 Reset mid-unload SHALL abort the row immediately; the bank contents need not be cleared.

Verification
REQ-032 Shift 64 columns with col k rgb = k[5:0], latch with a=5, out_ready=1 → 64 beats, out_row=5, plane 0, out_col/out_rgb 0..63 in order, then out_valid=0.
REQ-033 Latch row 5 four times, then row 6 → out_plane 0,1,2,3 for the row-5 latches, then 0 for row 6.
REQ-034 Shift 70 columns, then latch → err_overflow=1, 64 beats output; clr_err pulse → err_overflow=0.
REQ-035 Hold out_ready=0 across a second latch → err_overrun=1, the first row's pixel held stable, and its row completes after out_ready=1.
REQ-036 Blank low for 200 clk → on_valid pulse with on_time=200 ±2; blank low for 5000 clk with ONW=12 → on_time=4095.
REQ-037 Toggle out_ready randomly during unload → no pixel lost or duplicated, out_* stable while stalled.
